reg_cmd_ctrl: RTL
=================

REG_CMD_CTRL -- requirements
Module: reg_cmd_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the byte and register data width.
REQ-002 The block SHALL have parameter ADDRESS_SIZE, default 4, meaning the register address width.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the inter-byte timeout limit (used only with CMD_TIMEOUT_EN).
REQ-004 The block SHALL have port clk, input, 1 bit: system clock.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have ports rx_data (input, WIDTH) and rx_valid (input, 1): received byte and its one-cycle valid strobe.
REQ-007 The block SHALL have ports address (output, ADDRESS_SIZE) and wr_data (output, WIDTH): register-file address and write data.
REQ-008 The block SHALL have ports wr_en and rd_en (outputs, 1 each): register-file write and read strobes.
REQ-009 The block SHALL have ports rd_data (input, WIDTH) and rd_data_valid (input, 1): register-file read return.
REQ-010 The block SHALL have ports tx_data (output, WIDTH), tx_valid (output, 1) and tx_busy (input, 1): transmit byte handshake.
REQ-011 The block SHALL have ports cmd_error (output, 1), a one-cycle error pulse, and ctrl_busy (output, 1), high whenever the state is not IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND; a byte is accepted on a clk edge with rx_valid=1.
REQ-013 In IDLE: byte 0xAA -> WR_ADDR; byte 0xBB -> RD_ADDR; any other byte -> pulse cmd_error, stay in IDLE.
REQ-014 In WR_ADDR/RD_ADDR: an address byte with bits above ADDRESS_SIZE-1 nonzero SHALL pulse cmd_error and return to IDLE; otherwise it is latched onto address and the FSM moves to WR_DATA or RD_WAIT respectively.
REQ-015 In WR_DATA: a byte accepted at edge N SHALL drive wr_data = byte and wr_en = 1 for exactly the cycle following edge N, with rd_en = 0; the FSM returns to IDLE.
REQ-016 On entry to RD_WAIT, rd_en SHALL be 1 for exactly one cycle, with wr_en = 0.
REQ-017 The FSM SHALL remain in RD_WAIT until rd_data_valid = 1, capture rd_data into tx_data, assert tx_valid, and move to TX_SEND.
REQ-018 Read latency SHALL be: address byte at edge N, rd_en high after N, rd_data_valid sampled at N+2, tx_valid high after N+2 given a 1-cycle register file.
REQ-019 In TX_SEND, tx_valid and tx_data SHALL hold stable until an edge with tx_valid=1 and tx_busy=0; tx_valid then drops and the FSM returns to IDLE.
REQ-020 A byte arriving in RD_WAIT or TX_SEND SHALL be dropped and cmd_error pulsed, with no change in state.
REQ-021 wr_en and rd_en SHALL never be high in the same cycle.
REQ-022 address SHALL hold its last latched value outside active commands.

Reset
REQ-023 Asserting rst=0 SHALL immediately force state IDLE, and set address, wr_data, tx_data, wr_en, rd_en, tx_valid, cmd_error, ctrl_busy and the timeout counter to 0.
REQ-024 Reset during any command SHALL abort it with no wr_en, rd_en or tx_valid issued afterwards.

Configuration
REQ-025 With macro CMD_TIMEOUT_EN defined, a counter SHALL clear on each accepted byte and increment each cycle while in WR_ADDR, WR_DATA or RD_ADDR. On reaching TIMEOUT_CYCLES-1 it SHALL pulse cmd_error and force IDLE.
REQ-026 Without CMD_TIMEOUT_EN, no counter SHALL exist and these states SHALL wait indefinitely.

Verification
REQ-027 Bytes AA,05,3C -> one wr_en cycle with address=5 and wr_data=0x3C; no cmd_error.
REQ-028 Bytes BB,02, then rd_data=0x81 with rd_data_valid one cycle after rd_en, tx_busy=0 -> tx_valid high for one cycle with tx_data=0x81.
REQ-029 Read of address 3 with tx_busy=1 for 5 cycles -> tx_valid and tx_data=0x20 held stable for all 5 cycles; completes when tx_busy falls.
REQ-030 Byte 0x55 in IDLE -> cmd_error pulse; bytes AA,1F -> cmd_error and return to IDLE.
REQ-031 AA then rst=0 for 2 cycles, then byte 3C -> no wr_en; 3C treated as unknown command and cmd_error pulses.
REQ-032 With CMD_TIMEOUT_EN and TIMEOUT_CYCLES=16, AA then 20 idle cycles -> cmd_error at cycle 16 and return to IDLE.

Source files
------------

// File: rtl/reg_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// reg_cmd_ctrl
//
// Byte-stream command decoder that drives a simple register file.
//
//   Write command : 0xAA, <address>, <data>  -> one-cycle wr_en
//   Read command  : 0xBB, <address>          -> one-cycle rd_en, then the
//                   returned rd_data is offered on tx_data/tx_valid until the
//                   transmitter takes it (tx_busy low).
//
// Unknown command bytes, out-of-range addresses and bytes that arrive while a
// read is still in flight raise a one-cycle cmd_error pulse.
//
// All outputs are registered. Reset (rst) is asynchronous and active-low.
//
// Optional feature: define CMD_TIMEOUT_EN to abort a command that stalls in
// WR_ADDR, WR_DATA or RD_ADDR for TIMEOUT_CYCLES cycles. Without the macro
// those states wait indefinitely and no counter is built.
//
// Address bytes are checked against ADDRESS_SIZE: any set bit above
// ADDRESS_SIZE-1 is an error. ADDRESS_SIZE is expected to be <= WIDTH.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module reg_cmd_ctrl #(
  parameter int WIDTH          = 8,
  parameter int ADDRESS_SIZE   = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,

  // Received byte stream
  input  logic [WIDTH-1:0]        rx_data,
  input  logic                    rx_valid,

  // Register-file access
  output logic [ADDRESS_SIZE-1:0] address,
  output logic [WIDTH-1:0]        wr_data,
  output logic                    wr_en,
  output logic                    rd_en,
  input  logic [WIDTH-1:0]        rd_data,
  input  logic                    rd_data_valid,

  // Transmit handshake
  output logic [WIDTH-1:0]        tx_data,
  output logic                    tx_valid,
  input  logic                    tx_busy,

  // Status
  output logic                    cmd_error,
  output logic                    ctrl_busy
);

  // -------------------------------------------------------------------------
  // Command encoding and FSM states
  // -------------------------------------------------------------------------
  localparam logic [WIDTH-1:0] CMD_WRITE = WIDTH'(8'hAA);
  localparam logic [WIDTH-1:0] CMD_READ  = WIDTH'(8'hBB);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    RD_ADDR = 3'd3,
    RD_WAIT = 3'd4,
    TX_SEND = 3'd5
  } state_t;

  // -------------------------------------------------------------------------
  // Registered state and outputs, plus their next-cycle values
  // -------------------------------------------------------------------------
  state_t                  r_state;
  state_t                  w_next_state;

  logic [ADDRESS_SIZE-1:0] r_address;
  logic [ADDRESS_SIZE-1:0] w_next_address;
  logic [WIDTH-1:0]        r_wr_data;
  logic [WIDTH-1:0]        w_next_wr_data;
  logic [WIDTH-1:0]        r_tx_data;
  logic [WIDTH-1:0]        w_next_tx_data;
  logic                    r_wr_en;
  logic                    w_next_wr_en;
  logic                    r_rd_en;
  logic                    w_next_rd_en;
  logic                    r_tx_valid;
  logic                    w_next_tx_valid;
  logic                    r_cmd_error;
  logic                    w_next_cmd_error;
  logic                    r_ctrl_busy;

  // Address byte decode: the low bits become the register address, and the
  // byte is legal only when every bit above the address field is clear.
  logic [ADDRESS_SIZE-1:0] w_addr_field;
  logic                    w_addr_ok;

  assign w_addr_field = ADDRESS_SIZE'(rx_data);
  assign w_addr_ok    = ((rx_data >> ADDRESS_SIZE) == '0);

  // High for the one cycle in which a stalled command must be abandoned.
  logic                    w_timeout_hit;

`ifdef CMD_TIMEOUT_EN
  // -------------------------------------------------------------------------
  // Inter-byte timeout
  // -------------------------------------------------------------------------
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] r_timeout_cnt;
  logic            w_counting;

  // Only the states that wait on the sender are timed; RD_WAIT and TX_SEND
  // wait on the local register file and transmitter instead.
  assign w_counting    = (r_state == WR_ADDR) || (r_state == WR_DATA) ||
                         (r_state == RD_ADDR);
  // A byte arriving on the expiry edge still wins: it is a live sender.
  assign w_timeout_hit = w_counting && !rx_valid && (r_timeout_cnt == TO_LAST);

  // Count idle cycles inside a command; restart on every accepted byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_timeout_cnt <= '0;
    end else if (rx_valid || !w_counting || w_timeout_hit) begin
      r_timeout_cnt <= '0;
    end else begin
      r_timeout_cnt <= r_timeout_cnt + 1'b1;
    end
  end
`else
  // No timeout hardware: commands wait for their next byte indefinitely.
  // The parameter is kept so both builds share one interface.
  logic w_unused_timeout_cfg;

  assign w_timeout_hit        = 1'b0;
  assign w_unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  // Commit the next-state values computed below; reset aborts any command.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_address   <= '0;
      r_wr_data   <= '0;
      r_tx_data   <= '0;
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_tx_valid  <= 1'b0;
      r_cmd_error <= 1'b0;
      r_ctrl_busy <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // values from before this edge, independent of statement order.
      r_state     <= w_next_state;
      r_address   <= w_next_address;
      r_wr_data   <= w_next_wr_data;
      r_tx_data   <= w_next_tx_data;
      r_wr_en     <= w_next_wr_en;
      r_rd_en     <= w_next_rd_en;
      r_tx_valid  <= w_next_tx_valid;
      r_cmd_error <= w_next_cmd_error;
      // Registered from the next state so it tracks "state != IDLE" exactly.
      r_ctrl_busy <= (w_next_state != IDLE);
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and next-output logic
  // -------------------------------------------------------------------------
  // Decode the incoming byte against the current state.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // forgot one would otherwise infer a latch.
    w_next_state     = r_state;
    w_next_address   = r_address;     // address holds between commands
    w_next_wr_data   = r_wr_data;
    w_next_tx_data   = r_tx_data;
    w_next_wr_en     = 1'b0;          // strobes are single-cycle by default
    w_next_rd_en     = 1'b0;
    w_next_tx_valid  = r_tx_valid;
    w_next_cmd_error = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data == CMD_WRITE) begin
            w_next_state = WR_ADDR;
          end else if (rx_data == CMD_READ) begin
            w_next_state = RD_ADDR;
          end else begin
            w_next_cmd_error = 1'b1;
          end
        end
      end

      WR_ADDR: begin
        if (rx_valid) begin
          if (w_addr_ok) begin
            w_next_address = w_addr_field;
            w_next_state   = WR_DATA;
          end else begin
            w_next_cmd_error = 1'b1;
            w_next_state     = IDLE;
          end
        end else if (w_timeout_hit) begin
          w_next_cmd_error = 1'b1;
          w_next_state     = IDLE;
        end
      end

      WR_DATA: begin
        if (rx_valid) begin
          w_next_wr_data = rx_data;
          w_next_wr_en   = 1'b1;
          w_next_state   = IDLE;
        end else if (w_timeout_hit) begin
          w_next_cmd_error = 1'b1;
          w_next_state     = IDLE;
        end
      end

      RD_ADDR: begin
        if (rx_valid) begin
          if (w_addr_ok) begin
            // rd_en rises together with the move into RD_WAIT, so it is
            // high for exactly the first RD_WAIT cycle.
            w_next_address = w_addr_field;
            w_next_rd_en   = 1'b1;
            w_next_state   = RD_WAIT;
          end else begin
            w_next_cmd_error = 1'b1;
            w_next_state     = IDLE;
          end
        end else if (w_timeout_hit) begin
          w_next_cmd_error = 1'b1;
          w_next_state     = IDLE;
        end
      end

      RD_WAIT: begin
        // A byte here cannot be serviced; drop it but keep the read going.
        if (rx_valid) begin
          w_next_cmd_error = 1'b1;
        end
        if (rd_data_valid) begin
          w_next_tx_data  = rd_data;
          w_next_tx_valid = 1'b1;
          w_next_state    = TX_SEND;
        end
      end

      TX_SEND: begin
        if (rx_valid) begin
          w_next_cmd_error = 1'b1;
        end
        // tx_valid is always high in this state; the byte is taken on the
        // first edge where the transmitter is free.
        if (!tx_busy) begin
          w_next_tx_valid = 1'b0;
          w_next_state    = IDLE;
        end
      end

      default: begin
        w_next_tx_valid = 1'b0;
        w_next_state    = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign address   = r_address;
  assign wr_data   = r_wr_data;
  assign wr_en     = r_wr_en;
  assign rd_en     = r_rd_en;
  assign tx_data   = r_tx_data;
  assign tx_valid  = r_tx_valid;
  assign cmd_error = r_cmd_error;
  assign ctrl_busy = r_ctrl_busy;

endmodule
